spi_reg_master: RTL and testbench

Register-driven SPI master that sits between the AXI register file and the SPI pad IOBUFs, in place of the block-design SPI core. It takes transfer commands from register-file fields (tx data, length, divider, mode, start pulse) and runs one full-duplex transfer of 1–32 bits. It returns status and received data for the register file's read-back vector. It drives the `_o`/`_t` side of the IOBUFs for `spi_1_mosi`, `spi_1_sck` and `spi_1_csn`, and reads `spi_1_miso`.

---
 rtl/spi_reg_pkg.sv | 28 ++
 rtl/spi_half_period_timer.sv | 38 +++
 rtl/spi_reg_master.sv | 181 ++++++++++++++++++
 tb/tb_spi_reg_master.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// Shared types and register-map constants for the register-driven SPI master.
// Ctrl-word bit positions mirror the AXI register file's field layout.
package spi_reg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LEAD,
        ST_TRAIL,
        ST_HOLD
    } state_e;

    // Word offsets inside the register file
    localparam int unsigned REG_TX_IDX     = 0;
    localparam int unsigned REG_CTRL_IDX   = 1;
    localparam int unsigned REG_STATUS_IDX = 2;
    localparam int unsigned REG_RX_IDX     = 3;

    // Ctrl-word field positions
    localparam int unsigned CTRL_START_BIT = 0;
    localparam int unsigned CTRL_NBITS_LSB = 1;
    localparam int unsigned CTRL_NBITS_W   = 5;
    localparam int unsigned CTRL_CPOL_BIT  = 6;
    localparam int unsigned CTRL_CPHA_BIT  = 7;
    localparam int unsigned CTRL_OE_BIT    = 8;
    localparam int unsigned CTRL_DIV_LSB   = 16;

endpackage

// File: rtl/spi_half_period_timer.sv
// Half-period down-counter: loads H-1 on every FSM state entry and flags the
// last clock of the half period with a one-cycle tick.
module spi_half_period_timer
    import spi_reg_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         tick_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        tick_o = (cnt_q == '0);
    end

endmodule

// File: rtl/spi_reg_master.sv
// Register-driven full-duplex SPI master (1-32 bits, MSB first, all four modes).
// Optional SPI_REG_MASTER_LOOPBACK_EN adds a `loopback` input feeding mosi back to the sampler.
module spi_reg_master
    import spi_reg_pkg::*;
#(
    parameter int unsigned DIV_W = 8
) (
    input  logic             axi_aclk,
    input  logic             axi_reset,
    input  logic             start,
    input  logic [31:0]      tx_data,
    input  logic [4:0]       nbits_m1,
    input  logic [DIV_W-1:0] clk_div,
    input  logic             cpol,
    input  logic             cpha,
    input  logic             oe,
    output logic             busy,
    output logic             done,
    output logic [31:0]      rx_data,
    output logic             sck_o,
    output logic             sck_t,
    output logic             mosi_o,
    output logic             mosi_t,
    output logic             ss_o,
    output logic             ss_t,
    input  logic             miso_i
`ifdef SPI_REG_MASTER_LOOPBACK_EN
    ,
    input  logic             loopback
`endif
);

    state_e           state_q, state_d;
    logic             tick, load, accept, sample_bit;
    logic [DIV_W-1:0] load_val;
    logic [DIV_W-1:0] div_q, div_d;
    logic             cpol_q, cpol_d, cpha_q, cpha_d;
    logic [4:0]       bit_cnt_q, bit_cnt_d;
    logic [31:0]      tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_q, rx_d, aligned;
    logic             sck_q, sck_d, mosi_q, mosi_d, done_q, done_d;

    spi_half_period_timer #(.W(DIV_W)) u_timer (
        .clk_i      (axi_aclk),
        .rst_i      (axi_reset),
        .load_i     (load),
        .load_val_i (load_val),
        .tick_o     (tick)
    );

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        accept  = (state_q == ST_IDLE) && start;
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_SETUP;
            ST_SETUP: if (tick)  state_d = ST_LEAD;
            ST_LEAD:  if (tick)  state_d = ST_TRAIL;
            ST_TRAIL: if (tick)  state_d = (bit_cnt_q == '0) ? ST_HOLD : ST_LEAD;
            ST_HOLD:  if (tick)  state_d = ST_IDLE;
            default:             state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != ST_IDLE);
        ss_o     = (state_q == ST_IDLE);
        load     = (state_d != state_q);
        load_val = accept ? clk_div : div_q;
        sck_o    = sck_q;
        mosi_o   = mosi_q;
        done     = done_q;
        rx_data  = rx_q;
        sck_t    = ~oe;
        mosi_t   = ~oe;
        ss_t     = ~oe;
    end

    always_comb begin
`ifdef SPI_REG_MASTER_LOOPBACK_EN
        sample_bit = loopback ? mosi_q : miso_i;
`else
        sample_bit = miso_i;
`endif
    end

    // Transmit word is left-justified so the first bit always sits at bit 31
    always_comb begin
        aligned   = tx_data << (5'd31 - nbits_m1);
        div_d     = div_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        bit_cnt_d = bit_cnt_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_d      = rx_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        done_d    = done_q;
        if (accept) begin
            div_d     = clk_div;
            cpol_d    = cpol;
            cpha_d    = cpha;
            bit_cnt_d = nbits_m1;
            rx_sh_d   = '0;
            done_d    = 1'b0;
            sck_d     = cpol;
            if (cpha) begin
                mosi_d  = 1'b0;
                tx_sh_d = aligned;
            end else begin
                mosi_d  = aligned[31];
                tx_sh_d = aligned << 1;
            end
        end else if (state_q == ST_IDLE) begin
            sck_d  = cpol;
            mosi_d = 1'b0;
        end else if (load) begin
            case (state_d)
                ST_LEAD: begin
                    sck_d = ~sck_q;
                    if (state_q == ST_TRAIL) bit_cnt_d = bit_cnt_q - 5'd1;
                    if (cpha_q) begin
                        mosi_d  = tx_sh_q[31];
                        tx_sh_d = tx_sh_q << 1;
                    end
                end
                ST_TRAIL: begin
                    sck_d = ~sck_q;
                    if (!cpha_q) begin
                        mosi_d  = tx_sh_q[31];
                        tx_sh_d = tx_sh_q << 1;
                    end
                end
                ST_HOLD: sck_d = cpol_q;
                ST_IDLE: begin
                    done_d = 1'b1;
                    rx_d   = rx_sh_q;
                    mosi_d = 1'b0;
                end
                default: ;
            endcase
        end
        if (tick && ((state_q == ST_LEAD && !cpha_q) || (state_q == ST_TRAIL && cpha_q))) begin
            rx_sh_d = {rx_sh_q[30:0], sample_bit};
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            div_q     <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            bit_cnt_q <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_q      <= '0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            div_q     <= div_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            bit_cnt_q <= bit_cnt_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_q      <= rx_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_spi_reg_master.sv
// Directed bench for spi_reg_master with a behavioural SPI slave on the pads.
// Loopback checks are compiled in when SPI_REG_MASTER_LOOPBACK_EN is defined.
module tb_spi_reg_master;

    logic        clk = 1'b0;
    logic        axi_reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] tx_data = '0;
    logic [4:0]  nbits_m1 = '0;
    logic [7:0]  clk_div = '0;
    logic        cpol = 1'b0;
    logic        cpha = 1'b0;
    logic        oe = 1'b0;
    logic        busy, done;
    logic [31:0] rx_data;
    logic        sck_o, sck_t, mosi_o, mosi_t, ss_o, ss_t;
    logic        miso_i = 1'b0;
`ifdef SPI_REG_MASTER_LOOPBACK_EN
    logic        loopback = 1'b0;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;

    spi_reg_master #(.DIV_W(8)) dut (
        .axi_aclk  (clk),
        .axi_reset (axi_reset),
        .start     (start),
        .tx_data   (tx_data),
        .nbits_m1  (nbits_m1),
        .clk_div   (clk_div),
        .cpol      (cpol),
        .cpha      (cpha),
        .oe        (oe),
        .busy      (busy),
        .done      (done),
        .rx_data   (rx_data),
        .sck_o     (sck_o),
        .sck_t     (sck_t),
        .mosi_o    (mosi_o),
        .mosi_t    (mosi_t),
        .ss_o      (ss_o),
        .ss_t      (ss_t),
        .miso_i    (miso_i)
`ifdef SPI_REG_MASTER_LOOPBACK_EN
        ,
        .loopback  (loopback)
`endif
    );

    always #5 clk = ~clk;

    // Slave model and event counters, evaluated on the falling clock edge
    logic [31:0] s_tx = '0, s_rx = '0;
    int          s_n = 1, s_idx = 0;
    logic        s_cpol = 1'b0, s_cpha = 1'b0;
    logic        ss_prev = 1'b1, sck_prev = 1'b0, done_prev = 1'b0;
    int unsigned busy_cnt = 0, sck_rise_cnt = 0, done_rise_cnt = 0;

    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (sck_o && !sck_prev) sck_rise_cnt++;
        if (done && !done_prev) done_rise_cnt++;
        if (!ss_o && ss_prev) begin
            s_rx  = '0;
            s_idx = s_n - 1;
            if (!s_cpha) miso_i = s_tx[s_idx[4:0]];
        end else if (!ss_o && !ss_prev && sck_o != sck_prev) begin
            if (sck_o != s_cpol) begin
                if (!s_cpha) begin
                    s_rx = {s_rx[30:0], mosi_o};
                end else begin
                    if (s_idx >= 0) miso_i = s_tx[s_idx[4:0]];
                    s_idx--;
                end
            end else begin
                if (!s_cpha) begin
                    s_idx--;
                    if (s_idx >= 0) miso_i = s_tx[s_idx[4:0]];
                end else begin
                    s_rx = {s_rx[30:0], mosi_o};
                end
            end
        end
        ss_prev   = ss_o;
        sck_prev  = sck_o;
        done_prev = done;
    end

    int unsigned busy_snap, sck_snap, done_snap;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic xfer_start(input logic [31:0] tx, input logic [4:0] nb, input logic [7:0] div,
                              input logic pol, input logic pha, input logic [31:0] resp);
        @(negedge clk);
        s_tx = resp; s_n = int'(nb) + 1; s_cpol = pol; s_cpha = pha;
        cpol = pol;
        repeat (2) @(negedge clk);
        busy_snap = busy_cnt; sck_snap = sck_rise_cnt; done_snap = done_rise_cnt;
        tx_data = tx; nbits_m1 = nb; clk_div = div; cpha = pha; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int unsigned max_cycles);
        int unsigned n = 0;
        while (busy === 1'b1 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        // Reset with pads tristated
        repeat (3) @(negedge clk);
        check("rst_ss",    {31'b0, ss_o},   32'd1);
        check("rst_sck",   {31'b0, sck_o},  32'd0);
        check("rst_mosi",  {31'b0, mosi_o}, 32'd0);
        check("rst_busy",  {31'b0, busy},   32'd0);
        check("rst_done",  {31'b0, done},   32'd0);
        check("rst_rx",    rx_data,         32'd0);
        check("rst_t_all", {29'b0, sck_t, mosi_t, ss_t}, 32'd7);
        axi_reset = 1'b0;
        oe = 1'b1;
        @(negedge clk);
        check("oe_t_all",  {29'b0, sck_t, mosi_t, ss_t}, 32'd0);

        // Mode 0, 8 bits, H=1
        xfer_start(32'hA5, 5'd7, 8'd0, 1'b0, 1'b0, 32'h3C);
        check("m0_busy_rise", {31'b0, busy}, 32'd1);
        check("m0_ss_low",    {31'b0, ss_o}, 32'd0);
        wait_idle("m0_timeout", 100);
        check("m0_rx",   rx_data,         32'h0000003C);
        check("m0_done", {31'b0, done},   32'd1);
        check("m0_ss",   {31'b0, ss_o},   32'd1);
        @(negedge clk);
        check("m0_mosi_idle", {31'b0, mosi_o}, 32'd0);
        check("m0_slave",    s_rx,                    32'hA5);
        check("m0_busy_len", busy_cnt - busy_snap,    32'd18);
        check("m0_sck_rise", sck_rise_cnt - sck_snap, 32'd8);

        // Mode 3, 32 bits, H=4
        xfer_start(32'hDEADBEEF, 5'd31, 8'd3, 1'b1, 1'b1, 32'h76543210);
        wait_idle("m3_timeout", 400);
        check("m3_rx", rx_data, 32'h76543210);
        @(negedge clk);
        check("m3_slave",    s_rx,                      32'hDEADBEEF);
        check("m3_busy_len", busy_cnt - busy_snap,      32'd264);
        check("m3_sck_idle", {31'b0, sck_o},            32'd1);
        check("m3_done_cnt", done_rise_cnt - done_snap, 32'd1);

        // Second start mid-transfer is ignored; accepted start clears done
        xfer_start(32'hC3, 5'd7, 8'd1, 1'b0, 1'b0, 32'h81);
        check("ign_done_clr", {31'b0, done}, 32'd0);
        repeat (4) @(negedge clk);
        tx_data = 32'hFF; nbits_m1 = 5'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("ign_timeout", 100);
        check("ign_rx", rx_data, 32'h81);
        repeat (10) @(negedge clk);
        check("ign_slave",    s_rx,                      32'hC3);
        check("ign_busy_len", busy_cnt - busy_snap,      32'd36);
        check("ign_done_cnt", done_rise_cnt - done_snap, 32'd1);
        check("ign_idle",     {31'b0, busy},             32'd0);

        // Start in the cycle busy falls is ignored, start one cycle later is taken
        xfer_start(32'h0F, 5'd7, 8'd0, 1'b0, 1'b0, 32'hF0);
        repeat (17) @(negedge clk);
        check("edge_busy_last", {31'b0, busy}, 32'd1);
        s_tx = 32'h96;
        tx_data = 32'h69; start = 1'b1;
        @(negedge clk);
        check("edge_busy_fell", {31'b0, busy}, 32'd0);
        check("edge_done",      {31'b0, done}, 32'd1);
        check("edge_rx1",       rx_data,       32'hF0);
        @(negedge clk);
        start = 1'b0;
        check("edge_busy_again", {31'b0, busy}, 32'd1);
        check("edge_done_clr",   {31'b0, done}, 32'd0);
        wait_idle("edge_timeout", 100);
        check("edge_rx2", rx_data, 32'h96);
        @(negedge clk);
        check("edge_slave2", s_rx, 32'h69);

        // Mode 1, single bit, H=3
        xfer_start(32'h1, 5'd0, 8'd2, 1'b0, 1'b1, 32'h1);
        wait_idle("m1_timeout", 100);
        check("m1_rx", rx_data, 32'h1);
        @(negedge clk);
        check("m1_slave",    s_rx,                 32'h1);
        check("m1_busy_len", busy_cnt - busy_snap, 32'd12);

        // Reset during bit 3 aborts, then a clean transfer
        xfer_start(32'h96, 5'd7, 8'd1, 1'b0, 1'b0, 32'hFF);
        repeat (14) @(negedge clk);
        axi_reset = 1'b1;
        @(negedge clk);
        axi_reset = 1'b0;
        check("abort_ss",   {31'b0, ss_o},  32'd1);
        check("abort_busy", {31'b0, busy},  32'd0);
        check("abort_done", {31'b0, done},  32'd0);
        check("abort_rx",   rx_data,        32'd0);
        check("abort_sck",  {31'b0, sck_o}, 32'd0);
        xfer_start(32'h5A, 5'd7, 8'd0, 1'b0, 1'b0, 32'hC3);
        wait_idle("post_timeout", 100);
        check("post_rx",   rx_data,       32'hC3);
        check("post_done", {31'b0, done}, 32'd1);
        @(negedge clk);
        check("post_slave", s_rx, 32'h5A);

`ifdef SPI_REG_MASTER_LOOPBACK_EN
        loopback = 1'b1;
        xfer_start(32'h1234, 5'd15, 8'd0, 1'b0, 1'b0, 32'h0);
        wait_idle("lb_on_timeout", 100);
        check("lb_on_rx", rx_data, 32'h00001234);
        loopback = 1'b0;
        xfer_start(32'h1234, 5'd15, 8'd0, 1'b0, 1'b0, 32'h0);
        wait_idle("lb_off_timeout", 100);
        check("lb_off_rx", rx_data, 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
